ila_fifo_readout: RTL and testbench
===================================

Name: ila_fifo_readout

Overview:
- Downstream consumer of the ILA sample FIFO, in the FIFO read-clock domain (A_CLK).
- On a host start command, pops a requested number of sample words from the FIFO read port.
- Splits each word into bytes, least significant byte first, and emits them on a valid/ready byte stream toward the host link (UART/SPI transmitter).
- Flags FIFO read errors and counts words sent.

Parameters:
- DATA_WIDTH, 20, FIFO read-port word width (1..40).
- COUNT_WIDTH, 16, width of word-count request and words_sent counter.
- NBYTES (localparam), ceil(DATA_WIDTH/8), bytes emitted per word.

Ports:
- A_CLK  in  1  clock; all logic on posedge.
- F_RST_N  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle start pulse; ignored unless in IDLE.
- abort  in  1  stop the transfer after the current byte handshake.
- num_words  in  COUNT_WIDTH  words to transfer; sampled on an accepted start.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data; valid 1 cycle after a pop.
- fifo_rd_error  in  1  FIFO read-error flag.
- fifo_rd_en  out  1  FIFO pop (FIFO A_EN).
- m_tdata  out  8  byte stream data.
- m_tvalid  out  1  byte valid.
- m_tready  in  1  sink ready.
- m_tlast  out  1  marks the last byte of the last word.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse on DONE entry.
- rd_err  out  1  sticky; set when fifo_rd_error is seen high while busy; cleared by an accepted start.
- words_sent  out  COUNT_WIDTH  words fully transmitted in the current or last transfer.

Behaviour:
- Reset (async, any state): state=IDLE.
  - All outputs 0: fifo_rd_en, m_tdata, m_tvalid, m_tlast, busy, done, rd_err, words_sent.
  - Internal counters and shift register are 0.
- States: IDLE, POP, WAIT, SEND, DONE.
- IDLE:
  - Accepted start latches remaining=num_words, clears words_sent and rd_err.
  - If num_words==0, go to DONE; otherwise go to POP.
- POP: fifo_rd_en = (state==POP) && !fifo_empty, combinational.
  - If fifo_empty, stay in POP with no pop issued. There is no timeout; only abort or reset exits.
  - Otherwise go to WAIT.
- WAIT: capture fifo_rd_data into the shift register (zero-padded to 8*NBYTES), set byte_idx=0, go to SEND.
- SEND: m_tvalid=1 and m_tdata=shift[7:0].
  - On tvalid&&tready: shift right 8 and byte_idx++.
  - After byte NBYTES-1 is accepted: words_sent++ and remaining--. If remaining becomes 0, go to DONE; otherwise go to POP.
- m_tlast=1 during SEND when byte_idx==NBYTES-1 and remaining==1.
- Stream rules:
  - m_tdata and m_tvalid are registered.
  - Once m_tvalid is high, neither m_tvalid nor m_tdata changes until tready.
  - One byte per cycle maximum.
  - Back-to-back words cost 2 idle cycles (POP, WAIT).
- Latency: with the FIFO non-empty, the first m_tvalid is asserted 3 clocks after the start edge.
- DONE: done=1 for 1 cycle, then IDLE.
- abort:
  - In POP or WAIT: go to DONE at the next edge. A pop already issued in POP is discarded.
  - In SEND: takes effect right after the current byte handshake, then DONE. m_tlast is not asserted for aborted transfers.
  - In IDLE: ignored.
- Simultaneous start and abort in IDLE: start wins.
- rd_err: fifo_rd_error sampled each cycle while busy; set on 1, stays set until the next accepted start.
- Counter wrap: words_sent saturates at all-ones.

Test Plan:
- Basic transfer: DATA_WIDTH=20, FIFO holds 0xABCDE,0x12345; start with num_words=2, tready=1.
  - Bytes 0xDE,0xBC,0x0A,0x45,0x23,0x01.
  - m_tlast only on 0x01; done pulse; words_sent=2.
  - First tvalid 3 cycles after start.
- Backpressure: same data, tready toggles 1,0,0,1.
  - m_tdata held stable while tready=0.
  - No byte lost or duplicated; exactly 2 fifo_rd_en pulses.
- Empty FIFO stall: start num_words=1 with the FIFO empty for 10 cycles, then write 0x00055.
  - fifo_rd_en stays low while empty.
  - Bytes 0x55,0x00,0x00 with tlast on the last; busy high throughout.
- Zero count: start with num_words=0 → done 1 cycle later, no fifo_rd_en, no tvalid.
- Abort: num_words=4, tready=0, abort asserted during the first byte.
  - Byte held until tready=1, then DONE.
  - words_sent=0, tlast never asserted.
- Reset mid-SEND: drop F_RST_N asynchronously while m_tvalid=1.
  - All outputs 0 immediately; IDLE after release; the next start works normally.
  - rd_err set by fifo_rd_error=1 during a transfer stays 1 after DONE and clears on the next start.

Source files
------------

// File: rtl/ila_fifo_readout.sv
// Drains a requested number of words from the ILA sample FIFO and serialises each
// word LSB-first onto a registered valid/ready byte stream toward the host link.
`timescale 1ns/1ps
module ila_fifo_readout #(
  parameter int DATA_WIDTH  = 20,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   A_CLK,
  input  logic                   F_RST_N,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] num_words,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_error,
  output logic                   fifo_rd_en,
  output logic [7:0]             m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_err,
  output logic [COUNT_WIDTH-1:0] words_sent
);

  localparam int NBYTES = (DATA_WIDTH + 7) / 8;
  localparam int SW     = 8 * NBYTES;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, POP, WAIT, SEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] words_sent_q, words_sent_d;
  logic [SW-1:0]          shift_q, shift_d;
  logic [IW-1:0]          byte_idx_q, byte_idx_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic                   abort_pend_q, abort_pend_d;
  logic                   rd_err_q, rd_err_d;
  logic                   hs;
  logic                   word_end;
  logic                   stop;

  assign hs       = m_tvalid_q && m_tready;
  assign word_end = hs && (byte_idx_q == LAST_IDX);
  // An abort seen while a byte is stalled is remembered until that byte is taken.
  assign stop     = abort || abort_pend_q;

  always_ff @(posedge A_CLK or negedge F_RST_N) begin
    if (!F_RST_N) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      words_sent_q <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      m_tvalid_q   <= 1'b0;
      abort_pend_q <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      words_sent_q <= words_sent_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      m_tvalid_q   <= m_tvalid_d;
      abort_pend_q <= abort_pend_d;
      rd_err_q     <= rd_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    words_sent_d = words_sent_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    abort_pend_d = abort_pend_q;
    rd_err_d     = rd_err_q;

    if (state_q != IDLE && fifo_rd_error) begin
      rd_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d  = num_words;
          words_sent_d = '0;
          rd_err_d     = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = (num_words == '0) ? DONE : POP;
        end
      end
      POP: begin
        if (abort) begin
          state_d = DONE;
        end else if (!fifo_empty) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = DONE;
        end else begin
          shift_d                   = '0;
          shift_d[DATA_WIDTH-1:0]   = fifo_rd_data;
          byte_idx_d                = '0;
          state_d                   = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (hs) begin
          shift_d    = shift_q >> 8;
          byte_idx_d = byte_idx_q + 1'b1;
          if (word_end) begin
            if (words_sent_q != '1) begin
              words_sent_d = words_sent_q + 1'b1;
            end
            remaining_d = remaining_q - 1'b1;
          end
          if (stop) begin
            state_d = DONE;
          end else if (word_end) begin
            state_d = (remaining_q == COUNT_WIDTH'(1)) ? DONE : POP;
          end
        end
      end
      DONE: begin
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    m_tvalid_d = (state_d == SEND);
  end

  assign fifo_rd_en = (state_q == POP) && !fifo_empty;
  assign m_tdata    = shift_q[7:0];
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tvalid_q && (byte_idx_q == LAST_IDX) &&
                      (remaining_q == COUNT_WIDTH'(1)) && !abort_pend_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign rd_err     = rd_err_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_ila_fifo_readout.sv
// Directed bench for ila_fifo_readout: table-driven transfers plus stall, abort,
// reset and error-flag sequences against a small FIFO model.
`timescale 1ns/1ps
module tb_ila_fifo_readout;
  localparam int DW = 20;
  localparam int CW = 16;

  logic          A_CLK = 1'b0;
  logic          F_RST_N = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_error = 1'b0;
  logic          fifo_rd_en;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          busy;
  logic          done;
  logic          rd_err;
  logic [CW-1:0] words_sent;

  int checks = 0;
  int errors = 0;
  int bad_pop = 0;

  logic [DW-1:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;

  ila_fifo_readout #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .A_CLK(A_CLK), .F_RST_N(F_RST_N), .start(start), .abort(abort),
    .num_words(num_words), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_error(fifo_rd_error), .fifo_rd_en(fifo_rd_en), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy),
    .done(done), .rd_err(rd_err), .words_sent(words_sent)
  );

  always #5 A_CLK = ~A_CLK;

  // FIFO model: one-cycle read latency; reset flushes anything left behind.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge A_CLK or negedge F_RST_N) begin
    if (!F_RST_N) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr[3:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  always @(posedge A_CLK) begin
    if (fifo_rd_en && fifo_empty) bad_pop <= bad_pop + 1;
  end

  typedef struct {
    int          nw;
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    logic [3:0]  pat;
    logic [47:0] eb;
    int          nb;
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr++;
  endtask

  task automatic start_and_wait(input int n, output int lat);
    start     = 1'b1;
    num_words = n[CW-1:0];
    @(negedge A_CLK);
    start = 1'b0;
    lat   = 1;
    while (!m_tvalid && lat < 50) begin
      @(negedge A_CLK);
      lat++;
    end
  endtask

  task automatic collect(input int n, input logic [47:0] eb, input logic [3:0] pat,
                         input logic tlast_ok, input string tag);
    int got = 0;
    int cyc = 0;
    int pi = 0;
    logic hold = 1'b0;
    logic [7:0] held = '0;
    while (got < n && cyc < 200) begin
      if (m_tvalid) begin
        if (hold) chk({tag, " held byte"}, m_tdata, held);
        m_tready = pat[pi % 4];
        pi++;
        if (m_tready) begin
          chk({tag, " byte"}, m_tdata, eb[got*8 +: 8]);
          chk({tag, " tlast"}, m_tlast, (tlast_ok && got == n - 1));
          got++;
          hold = 1'b0;
        end else begin
          held = m_tdata;
          hold = 1'b1;
        end
      end else begin
        m_tready = 1'b0;
      end
      @(negedge A_CLK);
      cyc++;
    end
    m_tready = 1'b0;
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d bytes expected %0d", tag, got, n);
    end
  endtask

  initial begin
    int lat;
    int p0;
    int stall_bad;

    vecs[0] = '{2, 20'hABCDE, 20'h12345, 4'b1111, 48'h0123_450A_BCDE, 6};
    vecs[1] = '{2, 20'hABCDE, 20'h12345, 4'b1001, 48'h0123_450A_BCDE, 6};
    vecs[2] = '{1, 20'hFFFFF, 20'h00000, 4'b0101, 48'h0000_000F_FFFF, 3};

    #3 F_RST_N = 1'b0;
    repeat (3) @(negedge A_CLK);
    chk("reset outputs", {fifo_rd_en, m_tvalid, m_tlast, busy, done, rd_err}, 6'b0);
    chk("reset tdata", m_tdata, 8'h00);
    chk("reset words_sent", words_sent, 16'h0);
    F_RST_N = 1'b1;
    @(negedge A_CLK);

    for (int v = 0; v < 3; v++) begin
      push(vecs[v].w0);
      if (vecs[v].nw > 1) push(vecs[v].w1);
      p0 = rd_ptr;
      start_and_wait(vecs[v].nw, lat);
      chk("first tvalid latency", lat, 3);
      collect(vecs[v].nb, vecs[v].eb, vecs[v].pat, 1'b1, "table");
      chk("table done", done, 1'b1);
      chk("table tvalid after", m_tvalid, 1'b0);
      chk("table words_sent", words_sent, vecs[v].nw);
      chk("table pops", rd_ptr - p0, vecs[v].nw);
      chk("table rd_err", rd_err, 1'b0);
      @(negedge A_CLK);
      chk("table idle", {busy, done}, 2'b00);
    end

    // Empty FIFO: request stalls in POP until data arrives.
    p0        = rd_ptr;
    stall_bad = 0;
    start     = 1'b1;
    num_words = 16'd1;
    @(negedge A_CLK);
    start = 1'b0;
    repeat (10) begin
      if (fifo_rd_en || !busy || m_tvalid) stall_bad++;
      @(negedge A_CLK);
    end
    chk("stall no pop while empty", stall_bad, 0);
    push(20'h00055);
    collect(3, 48'h0000_0000_0055, 4'b1111, 1'b1, "stall");
    chk("stall done", done, 1'b1);
    chk("stall pops", rd_ptr - p0, 1);
    @(negedge A_CLK);

    // Abort during a stalled first byte.
    push(20'h11111); push(20'h22222); push(20'h33333); push(20'h44444);
    p0       = rd_ptr;
    m_tready = 1'b0;
    start_and_wait(4, lat);
    chk("abort first byte", m_tdata, 8'h11);
    abort = 1'b1;
    @(negedge A_CLK);
    abort = 1'b0;
    chk("abort byte held", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'h11, 1'b0});
    @(negedge A_CLK);
    chk("abort byte still held", {m_tvalid, m_tdata, m_tlast}, {1'b1, 8'h11, 1'b0});
    m_tready = 1'b1;
    @(negedge A_CLK);
    m_tready = 1'b0;
    chk("abort done", {done, m_tvalid, m_tlast}, 3'b100);
    chk("abort words_sent", words_sent, 16'd0);
    chk("abort pops", rd_ptr - p0, 1);
    @(negedge A_CLK);
    chk("abort idle", busy, 1'b0);

    // Asynchronous reset while a byte is presented.
    start_and_wait(3, lat);
    chk("pre-reset tvalid", {m_tvalid, m_tdata}, {1'b1, 8'h22});
    #2 F_RST_N = 1'b0;
    #1;
    chk("async reset outputs", {fifo_rd_en, m_tvalid, m_tlast, busy, done, rd_err}, 6'b0);
    chk("async reset tdata", m_tdata, 8'h00);
    chk("async reset words_sent", words_sent, 16'h0);
    @(negedge A_CLK);
    F_RST_N = 1'b1;
    @(negedge A_CLK);
    chk("post-reset idle", busy, 1'b0);

    // rd_err: ignored in IDLE, sticky while busy, cleared by the next start.
    fifo_rd_error = 1'b1;
    repeat (2) @(negedge A_CLK);
    chk("rd_err ignored idle", rd_err, 1'b0);
    push(20'h12345);
    start_and_wait(1, lat);
    fifo_rd_error = 1'b0;
    chk("post-reset latency", lat, 3);
    collect(3, 48'h0000_0001_2345, 4'b1111, 1'b1, "rderr");
    chk("rderr done", {done, rd_err}, 2'b11);
    @(negedge A_CLK);
    chk("rd_err sticky idle", rd_err, 1'b1);
    chk("rderr words_sent", words_sent, 16'd1);

    // Zero-count start: immediate DONE, clears rd_err and words_sent.
    p0        = rd_ptr;
    start     = 1'b1;
    num_words = 16'd0;
    @(negedge A_CLK);
    start = 1'b0;
    chk("zero done", {done, fifo_rd_en, m_tvalid}, 3'b100);
    chk("zero clears", {rd_err, words_sent}, 17'h0);
    @(negedge A_CLK);
    chk("zero idle", {busy, done, m_tvalid}, 3'b000);
    chk("zero pops", rd_ptr - p0, 0);
    chk("no pop while empty", bad_pop, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
